// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes, instruction field
// positions, R-type funct and I-type opcode values, decode result bundle.
package alu_issue_stage_pkg;

    typedef enum logic [2:0] {
        ALU_OR   = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SUB  = 3'b111
    } alu_op_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_NAND = 6'b101101;

    typedef struct packed {
        alu_op_e    op;
        logic       imm_sel;
        logic       sext;
        logic [4:0] rd;
        logic       illegal;
    } dec_t;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sext);
        return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: opcode/funct -> ALU opcode, immediate
// select and extension mode, writeback index and illegal flag.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_opc;
    logic [5:0] w_fn;
    logic       w_unused_bits;

    assign w_opc = i_instr[OPC_MSB:OPC_LSB];
    assign w_fn  = i_instr[FN_MSB:FN_LSB];
    // rs and shamt only matter to the operand path in the top level
    assign w_unused_bits = ^{i_instr[RS_MSB:RS_LSB], i_instr[SH_MSB:SH_LSB]};

    always_comb begin
        o_dec = '{op: ALU_ADD, imm_sel: 1'b0, sext: 1'b0, rd: 5'd0, illegal: 1'b1};
        if (w_opc == OPC_RTYPE) begin
            o_dec.illegal = 1'b0;
            o_dec.rd      = i_instr[RD_MSB:RD_LSB];
            case (w_fn)
                FN_ADD, FN_ADDU: o_dec.op = ALU_ADD;
                FN_SUB, FN_SUBU: o_dec.op = ALU_SUB;
                FN_AND:          o_dec.op = ALU_AND;
                FN_OR:           o_dec.op = ALU_OR;
                FN_XOR:          o_dec.op = ALU_XOR;
                FN_NOR:          o_dec.op = ALU_NOR;
                FN_NAND:         o_dec.op = ALU_NAND;
                FN_SLT, FN_SLTU: o_dec.op = ALU_SLT;
                default: begin
                    o_dec.illegal = 1'b1;
                    o_dec.rd      = 5'd0;
                end
            endcase
        end else begin
            o_dec.imm_sel = 1'b1;
            o_dec.rd      = i_instr[RT_MSB:RT_LSB];
            case (w_opc)
                OPC_ADDI: begin o_dec.op = ALU_ADD; o_dec.sext = 1'b1; end
                OPC_SLTI: begin o_dec.op = ALU_SLT; o_dec.sext = 1'b1; end
                OPC_ANDI: o_dec.op = ALU_AND;
                OPC_ORI:  o_dec.op = ALU_OR;
                OPC_XORI: o_dec.op = ALU_XOR;
                default: begin
                    o_dec.imm_sel = 1'b0;
                    o_dec.rd      = 5'd0;
                end
            endcase
            o_dec.illegal = !o_dec.imm_sel;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU through a single ID/EX register.
// ALU_ISSUE_FWD_EN: forward EX result into operands; otherwise stall on a match.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    dec_t        w_dec;
    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_stall;
    logic        w_accept;

    logic        r_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    alu_op_e     r_op;
    logic [4:0]  r_rd;
    logic        r_illegal;

    alu_op_decode u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign w_rs_idx = in_instr[RS_MSB:RS_LSB];
    assign w_rt_idx = in_instr[RT_MSB:RT_LSB];
    // index 0 is never a forwarding target
    assign w_rs_hit = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == w_rs_idx);
    assign w_rt_hit = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == w_rt_idx);

`ifdef ALU_ISSUE_FWD_EN
    assign w_rs_val = w_rs_hit ? fwd_data : in_rs_data;
    assign w_rt_val = w_rt_hit ? fwd_data : in_rt_data;
    assign w_stall  = 1'b0;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^fwd_data;
    assign w_rs_val = in_rs_data;
    assign w_rt_val = in_rt_data;
    assign w_stall  = w_rs_hit || w_rt_hit;
`endif

    always_comb begin
        w_a = 32'd0;
        w_b = 32'd0;
        if (!w_dec.illegal) begin
            w_a = w_rs_val;
            w_b = w_dec.imm_sel ? extend_imm(in_instr[IMM_MSB:IMM_LSB], w_dec.sext) : w_rt_val;
        end
    end

    assign in_ready = (!r_valid || out_ready) && !w_stall;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_op      <= ALU_OR;
            r_rd      <= 5'd0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_a       <= w_a;
            r_b       <= w_b;
            r_op      <= w_dec.op;
            r_rd      <= w_dec.rd;
            r_illegal <= w_dec.illegal;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_op      = r_op;
    assign out_rd      = r_rd;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: stimulus pushes expected issues,
// a negedge monitor compares whatever the ID/EX register presents.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_rs_data = 32'd0;
    logic [31:0] in_rt_data = 32'd0;
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = 5'd0;
    logic [31:0] fwd_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference decode from the instruction-set table; operand values already forwarded.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] va, input logic [31:0] vb);
        exp_t        e;
        int          opc;
        int          fn;
        logic [31:0] zx;
        logic [31:0] sx;
        opc = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        zx  = {16'h0000, ins[15:0]};
        sx  = 32'($signed(ins[15:0]));
        e   = '{a: 32'd0, b: 32'd0, op: 3'd3, rd: 5'd0, ill: 1'b1};
        if (opc == 0) begin
            e = '{a: va, b: vb, op: 3'd0, rd: ins[15:11], ill: 1'b0};
            case (fn)
                32, 33:  e.op = 3'd3;
                34, 35:  e.op = 3'd7;
                36:      e.op = 3'd1;
                37:      e.op = 3'd0;
                38:      e.op = 3'd2;
                39:      e.op = 3'd4;
                45:      e.op = 3'd5;
                42, 43:  e.op = 3'd6;
                default: e = '{a: 32'd0, b: 32'd0, op: 3'd3, rd: 5'd0, ill: 1'b1};
            endcase
        end else begin
            case (opc)
                8:  e = '{a: va, b: sx, op: 3'd3, rd: ins[20:16], ill: 1'b0};
                10: e = '{a: va, b: sx, op: 3'd6, rd: ins[20:16], ill: 1'b0};
                12: e = '{a: va, b: zx, op: 3'd1, rd: ins[20:16], ill: 1'b0};
                13: e = '{a: va, b: zx, op: 3'd0, rd: ins[20:16], ill: 1'b0};
                14: e = '{a: va, b: zx, op: 3'd2, rd: ins[20:16], ill: 1'b0};
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int         fn_tab[11] = '{32, 33, 34, 35, 36, 37, 38, 39, 45, 42, 43};
        int         opc_tab[5] = '{8, 10, 12, 13, 14};
        int         k;
        logic [4:0] rs;
        logic [4:0] rt;
        k  = int'($urandom_range(0, 19));
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        if (k < 11) return {6'd0, rs, rt, 5'($urandom), 5'($urandom), 6'(fn_tab[k])};
        if (k < 16) return {6'(opc_tab[k-11]), rs, rt, 16'($urandom)};
        return $urandom;
    endfunction

    // One cycle of stimulus, entered and left 1 time unit after a rising edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic vld, input logic ordy, input logic fl,
                        input logic fv, input logic [4:0] frd, input logic [31:0] fd);
        logic        hit_s;
        logic        hit_t;
        logic        stall;
        logic        exp_rdy;
        logic        acc;
        logic [31:0] va;
        logic [31:0] vb;
        exp_t        e;
        in_instr = ins; in_rs_data = rsd; in_rt_data = rtd;
        in_valid = vld; out_ready = ordy; flush = fl;
        fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
        hit_s = fv && (frd != 0) && (frd == ins[25:21]);
        hit_t = fv && (frd != 0) && (frd == ins[20:16]);
        va = rsd;
        vb = rtd;
`ifdef ALU_ISSUE_FWD_EN
        stall = 1'b0;
        if (hit_s) va = fd;
        if (hit_t) vb = fd;
`else
        stall = hit_s || hit_t;
`endif
        exp_rdy = ((q.size() == 0) || ordy) && !stall;
        acc     = vld && exp_rdy && !fl;
        e       = model(ins, va, vb);
        #2;
        n_tests++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %0b want %0b (instr %08h)", in_ready, exp_rdy, ins);
        end
        @(posedge clk);
        if (fl) q.delete();
        if (acc) q.push_back(e);
        #1;
    endtask

    always begin
        exp_t got;
        @(negedge clk);
        if (!rst) begin
            n_tests++;
            if (out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %0b want %0b", out_valid, (q.size() != 0));
            end else if (out_valid) begin
                got = {out_a, out_b, out_op, out_rd, out_illegal};
                n_tests++;
                if (got !== q[0]) begin
                    n_fail++;
                    $display("FAIL issue: got a=%08h b=%08h op=%0d rd=%0d ill=%0b want a=%08h b=%08h op=%0d rd=%0d ill=%0b",
                             out_a, out_b, out_op, out_rd, out_illegal,
                             q[0].a, q[0].b, q[0].op, q[0].rd, q[0].ill);
                end
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    initial begin
        int          dec_opc[5] = '{8, 10, 12, 13, 14};
        int          dec_fn[12] = '{32, 33, 34, 35, 36, 37, 38, 39, 45, 42, 43, 0};
        logic [31:0] ins;

        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, out_a, out_b, out_op, out_rd, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b a=%08h b=%08h op=%0d rd=%0d want all zero",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Decode coverage: rs=0x0F, rt=0x03, imm=0xFFFF, plus an undefined funct
        foreach (dec_fn[i])
            step({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'(dec_fn[i])}, 32'hF, 32'h3, 1, 1, 0, 0, 0, 0);
        foreach (dec_opc[i])
            step({6'(dec_opc[i]), 5'd1, 5'd2, 16'hFFFF}, 32'hF, 32'h3, 1, 1, 0, 0, 0, 0);
        step({6'b111111, 5'd1, 5'd2, 16'hFFFF}, 32'hF, 32'h3, 1, 1, 0, 0, 0, 0);

        // Back-pressure: three frozen cycles, then drain and reload together
        step({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'd32}, 32'h11, 32'h22, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step({6'd8, 5'd1, 5'd6, 16'h8000}, 32'h33, 32'h44, 1, 0, 0, 0, 0, 0);
        step({6'd8, 5'd1, 5'd6, 16'h8000}, 32'h33, 32'h44, 1, 1, 0, 0, 0, 0);
        step(32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0, 0);

        // Forward match on rs=5 (forwarded or stalled, per build), then index 0
        ins = {6'd0, 5'd5, 5'd2, 5'd7, 5'd0, 6'd32};
        step(ins, 32'h1234, 32'h5, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF);
        step(ins, 32'h1234, 32'h5, 1, 1, 0, 1, 5'd5, 32'hDEADBEEF);
        step(ins, 32'h1234, 32'h5, 1, 1, 0, 0, 5'd5, 32'hDEADBEEF);
        step({6'd0, 5'd0, 5'd2, 5'd7, 5'd0, 6'd32}, 32'h1234, 32'h5, 1, 1, 0, 1, 5'd0, 32'hDEADBEEF);
        step(32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0, 0);

        // Flush while holding, with a new instruction offered
        step({6'd13, 5'd1, 5'd2, 16'h00F0}, 32'h1, 32'h2, 1, 0, 0, 0, 0, 0);
        step({6'd14, 5'd1, 5'd2, 16'h0F00}, 32'h1, 32'h2, 1, 0, 1, 0, 0, 0);
        step(32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0, 0);

        // Reset while an issue is held
        step({6'd12, 5'd1, 5'd2, 16'hAAAA}, 32'hFFFF, 32'h2, 1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        q.delete();
        #1;
        n_tests++;
        if ({out_valid, out_a, out_b, out_op, out_rd, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%0b a=%08h b=%08h op=%0d rd=%0d want all zero",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b want 1", in_ready);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(rand_instr(), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);

        for (int i = 0; i < 3; i++)
            step(32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
